switch_scan_ctrl: RTL and testbench
===================================

Name: switch_scan_ctrl

Overview:
- Time-multiplexed controller that sequences one shared debounce comparator and one shared 7-segment encoder across N_SW board switches.
- Visits one switch per sample tick, in round-robin order.
- Drives the LEDR lamps and per-digit HEX registers from debounced switch state.
- Sits between raw board inputs (SW) and the board outputs (LEDR, HEX0..HEX5).

Parameters:
- N_SW, 6, number of switches, LEDs and digits serviced (1..6).
- SAMPLE_DIV, 50000, clock cycles between scan steps; must be >= 3.
- STABLE_CNT, 4, consecutive differing samples needed to accept a change; must be >= 1.

Ports:
- CLOCK_50  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- SW  input  N_SW  raw, asynchronous switch levels.
- LEDR  output  N_SW  debounced switch state, registered.
- HEX0..HEX5  output  8 each  active-low segments: bit0=a .. bit6=g, bit7=dp.
- changed  output  1  one-cycle pulse when any slot's debounced value flips.
- scan_idx  output  3  slot currently being serviced (debug).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Input synchronizer: SW passes through a 2-FF synchronizer before any use.
- Divider: div counts 0..SAMPLE_DIV-1 and wraps. tick=1 for the single cycle where div==SAMPLE_DIV-1.
- FSM states:
  - IDLE: wait for tick, then go to SAMPLE.
  - SAMPLE (1 cycle): compare sync_sw[idx] with stable[idx].
    - Equal: cnt[idx]<=0.
    - Differ and cnt[idx]==STABLE_CNT-1: stable[idx] toggles, cnt[idx]<=0, flip flag set.
    - Differ otherwise: cnt[idx]+1.
    - Always go to WRITE.
  - WRITE (1 cycle): the shared encoder maps stable[idx] to HEX register idx. 1 -> 8'hF9, 0 -> 8'hC0. LEDR[idx]<=stable[idx]. changed=flip flag. Clear the flag. idx wraps N_SW-1 -> 0. Go to IDLE.
- Only slot idx is written per visit. Other HEX/LEDR registers hold their value.
- HEX digits with index >= N_SW are held at 8'hFF (blank).
- SAMPLE_DIV >= 3 guarantees that tick never arrives outside IDLE. No tick queueing is required.
- Acceptance latency: a change held steady is accepted on its STABLE_CNT-th consecutive differing visit. Visits to one slot are N_SW*SAMPLE_DIV cycles apart. LEDR/HEX update 2 cycles after the accepting tick; add 2 cycles for sync.
- A bounce back to the stable value before acceptance resets cnt to 0; no output change.
- Reset values:
  - stable=0, all cnt=0, idx=0, div=0, state=IDLE.
  - LEDR=0, changed=0.
  - HEX0..HEX(N_SW-1)=8'hC0; remaining digits 8'hFF.
  - Synchronizer flops=0.
- Reset mid-operation (SAMPLE or WRITE): abandon the visit; nothing partial is committed; all reset values apply on the next edge.
- cnt width: clog2(STABLE_CNT+1); it never exceeds STABLE_CNT-1.

Optional Feature:
- Macro: SWITCH_SCAN_BLANK_EN.
- Defined: stable 0 encodes to 8'hFF (digit blank). Reset value of active digits is 8'hFF.
- Undefined: stable 0 encodes to 8'hC0 ('0'), as above.
- LEDR and changed are unaffected either way.

Decomposition:
- Shared package contents:
  - Segment constants SEG_ONE=8'hF9, SEG_ZERO=8'hC0, SEG_BLANK=8'hFF.
  - FSM state typedef {IDLE, SAMPLE, WRITE}.
  - Clog2-based width helper.
- Sub-module seg_digit_encoder (combinational, 1-bit in, 8-bit out). It is the single shared encoder instance, and SWITCH_SCAN_BLANK_EN is honoured inside it.
- Divider, FSM, counters and output registers stay in switch_scan_ctrl.

Test Plan (N_SW=6, SAMPLE_DIV=4, STABLE_CNT=3; slot revisit = 24 cycles):
- Reset, then 100 cycles idle -> LEDR=0, HEX0..5=8'hC0, changed never 1, scan_idx cycles 0..5.
- Hold SW[2]=1 from cycle 0 -> LEDR[2]=1 and HEX2=8'hF9 on the 3rd slot-2 visit. Exactly one changed pulse. Other outputs unchanged.
- Toggle SW[4] 1,0 between consecutive slot-4 visits, then hold 0 -> no output change; cnt[4] returns to 0.
- Assert RESET during SAMPLE while slot 3 has cnt=2 and SW[3]=1 -> all reset values next edge. A subsequent acceptance needs a full 3 further visits.
- SW=6'b111111 held -> all LEDs set within 3 full rounds. HEX0..5=8'hF9. Exactly six changed pulses.
- Build with SWITCH_SCAN_BLANK_EN, reset -> HEX0..5=8'hFF. Set SW[0]=1 -> HEX0=8'hF9; release -> HEX0 back to 8'hFF after 3 visits.

Source files
------------

// File: rtl/switch_scan_ctrl_pkg.sv
// Shared constants, FSM state type and width helper for the switch scan controller.
package switch_scan_ctrl_pkg;

    localparam logic [7:0] SEG_ONE   = 8'hF9;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int MAX_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        WRITE
    } scan_state_e;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/switch_scan_ctrl_if.sv
// Board-side signal bundle: raw switches in, lamps, 7-segment digits and debug out.
interface switch_scan_ctrl_if #(
    parameter int N_SW = 6
);
    logic [N_SW-1:0] SW;
    logic [N_SW-1:0] LEDR;
    logic [7:0]      HEX0;
    logic [7:0]      HEX1;
    logic [7:0]      HEX2;
    logic [7:0]      HEX3;
    logic [7:0]      HEX4;
    logic [7:0]      HEX5;
    logic            changed;
    logic [2:0]      scan_idx;

    modport master (
        input  SW,
        output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, changed, scan_idx
    );

    modport slave (
        output SW,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, changed, scan_idx
    );
endinterface

// File: rtl/switch_scan_ctrl_seg_digit_encoder.sv
// Shared 1-bit to active-low 7-segment encoder.
// SWITCH_SCAN_BLANK_EN: a 0 input blanks the digit instead of showing '0'.
module seg_digit_encoder
    import switch_scan_ctrl_pkg::*;
(
    input  logic       bit_in,
    output logic [7:0] seg
);

`ifdef SWITCH_SCAN_BLANK_EN
    assign seg = bit_in ? SEG_ONE : SEG_BLANK;
`else
    assign seg = bit_in ? SEG_ONE : SEG_ZERO;
`endif

endmodule

// File: rtl/switch_scan_ctrl.sv
// Round-robin debounce and 7-segment display controller sharing one comparator and encoder.
// SWITCH_SCAN_BLANK_EN: active digits reset to, and show 0 as, a blank digit.
module switch_scan_ctrl
    import switch_scan_ctrl_pkg::*;
#(
    parameter int N_SW       = 6,
    parameter int SAMPLE_DIV = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    switch_scan_ctrl_if.master   bus
);

    localparam int DIV_W = width_for(SAMPLE_DIV);
    localparam int CNT_W = width_for(STABLE_CNT + 1);
    localparam int IDX_W = width_for(N_SW);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(N_SW - 1);

`ifdef SWITCH_SCAN_BLANK_EN
    localparam logic [7:0] SEG_RST = SEG_BLANK;
`else
    localparam logic [7:0] SEG_RST = SEG_ZERO;
`endif

    logic [N_SW-1:0]  sw_meta_q, sw_meta_d;
    logic [N_SW-1:0]  sw_sync_q, sw_sync_d;
    logic [DIV_W-1:0] div_q, div_d;
    scan_state_e      state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [N_SW-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];
    logic             flip_q, flip_d;
    logic [N_SW-1:0]  ledr_q, ledr_d;
    logic [7:0]       hex_q [MAX_DIGITS];
    logic [7:0]       hex_d [MAX_DIGITS];
    logic             changed_q, changed_d;

    logic             tick;
    logic [IDX_W-1:0] slot;
    logic [7:0]       enc_seg;

    assign tick = (div_q == DIV_LAST);
    assign slot = idx_q[IDX_W-1:0];

    seg_digit_encoder u_enc (
        .bit_in (stable_q[slot]),
        .seg    (enc_seg)
    );

    always_comb begin
        sw_meta_d = bus.SW;
        sw_sync_d = sw_meta_q;
        div_d     = tick ? '0 : div_q + 1'b1;
        state_d   = state_q;
        idx_d     = idx_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        flip_d    = flip_q;
        ledr_d    = ledr_q;
        hex_d     = hex_q;
        changed_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (sw_sync_q[slot] == stable_q[slot]) begin
                    cnt_d[slot] = '0;
                end else if (cnt_q[slot] == CNT_LAST) begin
                    stable_d[slot] = ~stable_q[slot];
                    cnt_d[slot]    = '0;
                    flip_d         = 1'b1;
                end else begin
                    cnt_d[slot] = cnt_q[slot] + 1'b1;
                end
                state_d = WRITE;
            end
            WRITE: begin
                // The encoder already sees the freshly updated stable bit for this slot.
                hex_d[slot]  = enc_seg;
                ledr_d[slot] = stable_q[slot];
                changed_d    = flip_q;
                flip_d       = 1'b0;
                idx_d        = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            div_q     <= '0;
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            stable_q  <= '0;
            flip_q    <= 1'b0;
            ledr_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < N_SW; i++) cnt_q[i] <= '0;
            for (int i = 0; i < MAX_DIGITS; i++) hex_q[i] <= (i < N_SW) ? SEG_RST : SEG_BLANK;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            div_q     <= div_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            stable_q  <= stable_d;
            flip_q    <= flip_d;
            ledr_q    <= ledr_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            hex_q     <= hex_d;
        end
    end

    assign bus.LEDR     = ledr_q;
    assign bus.HEX0     = hex_q[0];
    assign bus.HEX1     = hex_q[1];
    assign bus.HEX2     = hex_q[2];
    assign bus.HEX3     = hex_q[3];
    assign bus.HEX4     = hex_q[4];
    assign bus.HEX5     = hex_q[5];
    assign bus.changed  = changed_q;
    assign bus.scan_idx = idx_q;

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Bench for switch_scan_ctrl: directed table, corner sequences and random stimulus vs a visit-level model.
module tb_switch_scan_ctrl;
    import switch_scan_ctrl_pkg::*;

    localparam int N  = 6;
    localparam int SD = 4;
    localparam int SC = 3;

`ifdef SWITCH_SCAN_BLANK_EN
    localparam logic [7:0] SEG0 = 8'hFF;
`else
    localparam logic [7:0] SEG0 = 8'hC0;
`endif
    localparam logic [7:0] SEG1 = 8'hF9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_scan_ctrl_if #(.N_SW(N)) bus ();

    switch_scan_ctrl #(.N_SW(N), .SAMPLE_DIV(SD), .STABLE_CNT(SC)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    typedef struct {
        int at;
        int slot;
        bit val;
        bit flip;
    } upd_t;

    typedef struct {
        logic [5:0]      sw;
        int              hold;
        logic [5:0]      ledr;
        logic [5:0][7:0] hex;
        int              pulses;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: debounce decided per visit, outputs scheduled on a timeline.
    int              cyc;
    int              obs_cyc;
    int              vis;
    bit              m_stable [N];
    int              m_cnt    [N];
    logic [N-1:0]    sw_prev;
    logic [N-1:0]    exp_ledr;
    logic [5:0][7:0] exp_hex;
    bit              exp_chg;
    int              exp_idx;
    upd_t            pend [$];
    bit              trig3;
    int              pulses;
    logic [N-1:0]    obs_ledr;
    logic [5:0][7:0] obs_hex;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        vis      = 0;
        sw_prev  = '0;
        exp_ledr = '0;
        exp_chg  = 1'b0;
        exp_idx  = 0;
        pend.delete();
        for (int i = 0; i < N; i++) begin
            m_stable[i] = 1'b0;
            m_cnt[i]    = 0;
        end
        for (int i = 0; i < 6; i++) exp_hex[i] = (i < N) ? SEG0 : 8'hFF;
    endtask

    task automatic model_tick();
        int  slot;
        bit  s;
        bit  flip;
        if (cyc % SD == SD - 1) begin
            slot = vis % N;
            vis++;
            s    = sw_prev[slot];
            flip = 1'b0;
            if (slot == 3 && m_cnt[3] == 2 && s != m_stable[3]) trig3 = 1'b1;
            if (s == m_stable[slot]) begin
                m_cnt[slot] = 0;
            end else if (m_cnt[slot] == SC - 1) begin
                m_stable[slot] = ~m_stable[slot];
                m_cnt[slot]    = 0;
                flip           = 1'b1;
            end else begin
                m_cnt[slot]++;
            end
            pend.push_back('{cyc + 3, slot, m_stable[slot], flip});
        end
    endtask

    task automatic run_cycle(input logic [5:0] sw, input logic r, input bit chk);
        @(negedge clk);
        exp_chg = 1'b0;
        while (pend.size() > 0 && pend[0].at == cyc) begin
            exp_ledr[pend[0].slot] = pend[0].val;
            exp_hex[pend[0].slot]  = pend[0].val ? SEG1 : SEG0;
            exp_chg                = pend[0].flip;
            exp_idx                = (pend[0].slot + 1) % N;
            void'(pend.pop_front());
        end
        obs_cyc  = cyc;
        obs_ledr = bus.LEDR;
        obs_hex  = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
        if (chk) begin
            check($sformatf("cycle%0d", obs_cyc),
                  {obs_ledr, obs_hex, bus.changed, bus.scan_idx},
                  {exp_ledr, exp_hex, exp_chg, 3'(exp_idx)});
            if (bus.changed === 1'b1) pulses++;
        end
        bus.SW = sw;
        rst    = r;
        if (r) begin
            model_reset();
        end else begin
            model_tick();
            sw_prev = sw;
            cyc++;
        end
    endtask

    initial begin
        int found;
        logic [5:0] rsw;

        rst    = 1'b1;
        bus.SW = '0;
        trig3  = 1'b0;
        pulses = 0;
        model_reset();
        run_cycle(6'h00, 1'b1, 1'b0);
        run_cycle(6'h00, 1'b1, 1'b0);

        vecs[0] = '{sw: 6'h00, hold: 100, ledr: 6'h00, hex: {6{SEG0}}, pulses: 0};
        vecs[1] = '{sw: 6'h04, hold: 80,  ledr: 6'h04, hex: {SEG0, SEG0, SEG0, SEG1, SEG0, SEG0}, pulses: 1};
        vecs[2] = '{sw: 6'h3F, hold: 80,  ledr: 6'h3F, hex: {6{SEG1}}, pulses: 5};
        vecs[3] = '{sw: 6'h00, hold: 80,  ledr: 6'h00, hex: {6{SEG0}}, pulses: 6};
        vecs[4] = '{sw: 6'h3F, hold: 80,  ledr: 6'h3F, hex: {6{SEG1}}, pulses: 6};
        vecs[5] = '{sw: 6'h2A, hold: 80,  ledr: 6'h2A, hex: {SEG1, SEG0, SEG1, SEG0, SEG1, SEG0}, pulses: 3};

        // Reset state observed directly.
        run_cycle(6'h00, 1'b0, 1'b1);
        check("reset_ledr", 64'(bus.LEDR), 64'h0);
        check("reset_hex", 64'(obs_hex), 64'({6{SEG0}}));
        check("reset_changed", 64'(bus.changed), 64'h0);
        check("reset_scan_idx", 64'(bus.scan_idx), 64'h0);

        for (int v = 0; v < 6; v++) begin
            pulses = 0;
            for (int k = 0; k < vecs[v].hold; k++) run_cycle(vecs[v].sw, 1'b0, 1'b1);
            check($sformatf("vec%0d_ledr", v), 64'(obs_ledr), 64'(vecs[v].ledr));
            check($sformatf("vec%0d_hex", v), 64'(obs_hex), 64'(vecs[v].hex));
            check($sformatf("vec%0d_pulses", v), 64'(pulses), 64'(vecs[v].pulses));
        end

        // Bounce on SW[4]: one differing visit, then equal; later two differing visits only.
        run_cycle(6'h00, 1'b1, 1'b1);
        pulses = 0;
        for (int k = 0; k <= 230; k++) begin
            if (k <= 30 || (k >= 121 && k <= 170)) run_cycle(6'h10, 1'b0, 1'b1);
            else                                   run_cycle(6'h00, 1'b0, 1'b1);
        end
        check("bounce_ledr", 64'(obs_ledr), 64'h0);
        check("bounce_hex4", 64'(obs_hex[4]), 64'(SEG0));
        check("bounce_pulses", 64'(pulses), 64'h0);

        // Reset during SAMPLE of slot 3 while its count is at 2.
        run_cycle(6'h00, 1'b1, 1'b1);
        trig3 = 1'b0;
        for (int k = 0; k < 200 && !trig3; k++) run_cycle(6'h08, 1'b0, 1'b1);
        check("reach_slot3_cnt2", 64'(trig3), 64'h1);
        trig3 = 1'b0;
        run_cycle(6'h08, 1'b1, 1'b1);
        run_cycle(6'h08, 1'b0, 1'b1);
        check("midrst_ledr", 64'(obs_ledr), 64'h0);
        check("midrst_hex3", 64'(obs_hex[3]), 64'(SEG0));
        check("midrst_scan_idx", 64'(bus.scan_idx), 64'h0);
        found  = -1;
        pulses = 0;
        for (int k = 0; k < 200 && found < 0; k++) begin
            run_cycle(6'h08, 1'b0, 1'b1);
            if (obs_ledr[3] === 1'b1) found = obs_cyc;
        end
        check("midrst_accept_cycle", 64'(found), 64'd66);
        check("midrst_pulses", 64'(pulses), 64'h1);

        // Random slow-moving switches with an occasional reset.
        run_cycle(6'h00, 1'b1, 1'b1);
        rsw = '0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 24) == 0) rsw[$urandom_range(0, N - 1)] ^= 1'b1;
            run_cycle(rsw, ($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
